// File: rtl/match_len_extender.sv
// match_len_extender: accumulates a full LZ77 match length across successive compare windows
//   start_*  : first-window result from the match-length encoder (valid/ready, tag, len, can_ext)
//   fetch_*  : request for the next compare window at byte offset = accumulated length
//   seg_*    : returned window result (valid/ready, len, can_ext)
//   out_*    : final result to the token emitter (valid/ready, tag, len, ext_cnt)
module match_len_extender #(
    parameter int SEG_WIDTH     = 16,
    parameter int SEG_LEN_WIDTH = 5,
    parameter int MAX_MATCH_LEN = 258,
    parameter int LEN_WIDTH     = 9,
    parameter int TAG_WIDTH     = 8,
    parameter int CNT_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [TAG_WIDTH-1:0]     start_tag,
    input  logic [SEG_LEN_WIDTH-1:0] start_len,
    input  logic                     start_can_ext,
    output logic                     fetch_valid,
    input  logic                     fetch_ready,
    output logic [LEN_WIDTH-1:0]     fetch_offset,
    input  logic                     seg_valid,
    output logic                     seg_ready,
    input  logic [SEG_LEN_WIDTH-1:0] seg_len,
    input  logic                     seg_can_ext,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [LEN_WIDTH-1:0]     out_len,
    output logic [CNT_WIDTH-1:0]     out_ext_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [SEG_LEN_WIDTH-1:0] FULL  = SEG_LEN_WIDTH'(SEG_WIDTH);
    localparam logic [LEN_WIDTH-1:0]     MAX_L = LEN_WIDTH'(MAX_MATCH_LEN);
    localparam logic [LEN_WIDTH:0]       MAX_W = (LEN_WIDTH+1)'(MAX_MATCH_LEN);

    state_t                 state, state_nx;
    logic [LEN_WIDTH-1:0]   len, len_nx;
    logic [TAG_WIDTH-1:0]   tag, tag_nx;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nx;
    logic [LEN_WIDTH:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len   <= '0;
            tag   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            len   <= len_nx;
            tag   <= tag_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        len_nx   = len;
        tag_nx   = tag;
        cnt_nx   = cnt;
        // one bit wider than len so the saturation test cannot be fooled by wrap
        sum      = {1'b0, len} + (LEN_WIDTH+1)'(seg_len);
        case (state)
            IDLE: if (start_valid) begin
                tag_nx   = start_tag;
                len_nx   = LEN_WIDTH'(start_len);
                cnt_nx   = '0;
                state_nx = (start_can_ext && start_len == FULL && LEN_WIDTH'(start_len) < MAX_L) ? REQ : DONE;
            end
            REQ: if (fetch_ready) state_nx = WAIT;
            WAIT: if (seg_valid) begin
                cnt_nx = &cnt ? cnt : cnt + CNT_WIDTH'(1);
                if (sum >= MAX_W) begin
                    len_nx   = MAX_L;
                    state_nx = DONE;
                end else begin
                    len_nx   = sum[LEN_WIDTH-1:0];
                    // a partial window claiming can_ext is inconsistent and ends the match
                    state_nx = (seg_can_ext && seg_len == FULL) ? REQ : DONE;
                end
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign start_ready  = state == IDLE;
    assign fetch_valid  = state == REQ;
    assign seg_ready    = state == WAIT;
    assign out_valid    = state == DONE;
    assign fetch_offset = len;
    assign out_len      = len;
    assign out_tag      = tag;
    assign out_ext_cnt  = cnt;
endmodule

// File: tb/tb_match_len_extender.sv
// tb_match_len_extender: randomized self-checking bench with an arithmetic reference model
module tb_match_len_extender;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start_valid = 0, start_can_ext = 0;
    logic [7:0] start_tag = 0;
    logic [4:0] start_len = 0;
    logic       fetch_ready = 0;
    logic       seg_valid = 0, seg_can_ext = 0;
    logic [4:0] seg_len = 0;
    logic       out_ready = 0;
    logic       start_ready, fetch_valid, seg_ready, out_valid;
    logic [8:0] fetch_offset, out_len;
    logic [7:0] out_tag;
    logic [4:0] out_ext_cnt;

    int chk = 0, err = 0;
    int seg_l [0:31];
    bit seg_e [0:31];

    match_len_extender dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_tag(start_tag),
        .start_len(start_len), .start_can_ext(start_can_ext),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_offset(fetch_offset),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_len(seg_len), .seg_can_ext(seg_can_ext),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_len(out_len), .out_ext_cnt(out_ext_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one job; the model follows the extension rules with plain integer arithmetic.
    task automatic do_job(input int sl, input bit se, input int tg, input int fh, input int sd, input int oh);
        int  len, cnt, k;
        bit  more;
        len  = sl;
        cnt  = 0;
        k    = 0;
        more = se && sl == 16 && sl < 258;
        chk++;
        if (start_ready !== 1'b1) begin err++; $display("FAIL job_start_ready got %0b want 1", start_ready); end
        start_valid = 1; start_len = 5'(sl); start_can_ext = se; start_tag = 8'(tg);
        step();
        start_valid = 0;
        while (more) begin
            chk++;
            if (fetch_valid !== 1'b1 || fetch_offset !== 9'(len)) begin
                err++; $display("FAIL fetch got v=%0b off=%0d want v=1 off=%0d", fetch_valid, fetch_offset, len);
            end
            for (int h = 0; h < fh; h++) begin
                step();
                chk++;
                if (fetch_valid !== 1'b1 || fetch_offset !== 9'(len) || start_ready !== 1'b0) begin
                    err++; $display("FAIL fetch_hold got v=%0b off=%0d sr=%0b want v=1 off=%0d sr=0", fetch_valid, fetch_offset, start_ready, len);
                end
            end
            fetch_ready = 1;
            step();
            fetch_ready = 0;
            for (int d = 0; d <= sd; d++) begin
                chk++;
                if (seg_ready !== 1'b1 || fetch_valid !== 1'b0 || out_valid !== 1'b0) begin
                    err++; $display("FAIL wait got sr=%0b fv=%0b ov=%0b want 1 0 0", seg_ready, fetch_valid, out_valid);
                end
                if (d < sd) step();
            end
            seg_valid = 1; seg_len = 5'(seg_l[k]); seg_can_ext = seg_e[k];
            step();
            seg_valid = 0;
            cnt++;
            if (len + seg_l[k] >= 258) begin
                len  = 258;
                more = 0;
            end else begin
                len  = len + seg_l[k];
                more = seg_e[k] && seg_l[k] == 16;
            end
            k++;
        end
        for (int h = 0; h <= oh; h++) begin
            chk++;
            if (out_valid !== 1'b1 || out_len !== 9'(len) || out_ext_cnt !== 5'(cnt) || out_tag !== 8'(tg)
                || fetch_valid !== 1'b0 || start_ready !== 1'b0) begin
                err++;
                $display("FAIL out got v=%0b len=%0d cnt=%0d tag=%0d fv=%0b sr=%0b want v=1 len=%0d cnt=%0d tag=%0d fv=0 sr=0",
                         out_valid, out_len, out_ext_cnt, out_tag, fetch_valid, start_ready, len, cnt, tg);
            end
            if (h < oh) step();
        end
        out_ready = 1;
        step();
        out_ready = 0;
        chk++;
        if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
            err++; $display("FAIL out_done got ov=%0b sr=%0b want 0 1", out_valid, start_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        chk++;
        if (start_valid !== 1'b0 || fetch_valid !== 1'b0 || seg_ready !== 1'b0 || out_valid !== 1'b0
            || out_len !== 9'd0 || out_ext_cnt !== 5'd0 || out_tag !== 8'd0 || fetch_offset !== 9'd0) begin
            err++; $display("FAIL reset got fv=%0b sr=%0b ov=%0b len=%0d cnt=%0d tag=%0d want all 0",
                            fetch_valid, seg_ready, out_valid, out_len, out_ext_cnt, out_tag);
        end
        step(); step();
        rst_n = 1;
        step();
        chk++;
        if (start_ready !== 1'b1) begin err++; $display("FAIL reset_idle start_ready got %0b want 1", start_ready); end
    endtask

    task automatic test_no_ext();
        do_job(7, 0, 8'h11, 0, 0, 0);
        do_job(16, 0, 8'h12, 0, 0, 1);
        do_job(0, 1, 8'h13, 0, 0, 0);
    endtask

    task automatic test_two_ext();
        seg_l[0] = 16; seg_e[0] = 1;
        seg_l[1] = 5;  seg_e[1] = 0;
        do_job(16, 1, 8'h21, 0, 0, 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 32; i++) begin seg_l[i] = 16; seg_e[i] = 1; end
        do_job(16, 1, 8'h31, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        seg_l[0] = 16; seg_e[0] = 1;
        seg_l[1] = 3;  seg_e[1] = 1;
        do_job(16, 1, 8'h41, 3, 2, 5);
    endtask

    task automatic test_inconsistent();
        seg_l[0] = 9; seg_e[0] = 1;
        do_job(16, 1, 8'h61, 0, 0, 0);
    endtask

    task automatic test_reset_midjob();
        start_valid = 1; start_len = 16; start_can_ext = 1; start_tag = 8'h51;
        step();
        start_valid = 0;
        fetch_ready = 1;
        step();
        fetch_ready = 0;
        chk++;
        if (seg_ready !== 1'b1) begin err++; $display("FAIL mid_wait seg_ready got %0b want 1", seg_ready); end
        #2 rst_n = 0;
        #1;
        chk++;
        if (fetch_valid !== 1'b0 || seg_ready !== 1'b0 || out_valid !== 1'b0) begin
            err++; $display("FAIL async_reset got fv=%0b sr=%0b ov=%0b want 0 0 0", fetch_valid, seg_ready, out_valid);
        end
        step();
        rst_n = 1;
        step();
        chk++;
        if (start_ready !== 1'b1) begin err++; $display("FAIL post_reset start_ready got %0b want 1", start_ready); end
        seg_valid = 1; seg_len = 16; seg_can_ext = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk++;
            if (seg_ready !== 1'b0 || start_ready !== 1'b1 || fetch_valid !== 1'b0 || out_valid !== 1'b0) begin
                err++; $display("FAIL stray_seg got sr=%0b st=%0b fv=%0b ov=%0b want 0 1 0 0", seg_ready, start_ready, fetch_valid, out_valid);
            end
        end
        seg_valid = 0;
        do_job(4, 0, 8'h52, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            int  sl;
            bit  se;
            if ($urandom_range(0, 9) < 7) begin sl = 16; se = 1; end
            else begin sl = $urandom_range(0, 16); se = $urandom_range(0, 1) == 1; end
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 7) != 0) begin seg_l[i] = 16; seg_e[i] = 1; end
                else begin seg_l[i] = $urandom_range(0, 16); seg_e[i] = $urandom_range(0, 1) == 1; end
            end
            do_job(sl, se, $urandom_range(0, 255), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_no_ext();
        test_two_ext();
        test_saturate();
        test_backpressure();
        test_reset_midjob();
        test_inconsistent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
